// File: rtl/gpr_debug_port.sv
// gpr_debug_port: debug initiator that runs write, clear-all and ranged dump
// commands on the 32x32 GPR file and streams dumped values out as (idx, data) beats.
module gpr_debug_port (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_lo,
    input  logic [4:0]  cmd_hi,
    input  logic [31:0] cmd_wdata,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [4:0]  RD,
    output logic        RegWrite,
    output logic [31:0] WData,
    input  logic [31:0] RData1,
    input  logic [31:0] RData2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, WR, CLR, DUMP_RD, DUMP_OUT} state_t;
    state_t state, next;
    logic [4:0] ptr, hi;
    logic [31:0] wdata;
    logic accept, reject;
    logic unused;
    assign unused = ^RData2;
    always_comb begin
        next = state;
        accept = 1'b0;
        reject = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                reject = cmd_op == 2'b11 || (cmd_op == 2'b00 && cmd_lo > cmd_hi);
                accept = !reject;
                next = reject ? IDLE : cmd_op == 2'b01 ? WR : cmd_op == 2'b10 ? CLR : DUMP_RD;
            end
            WR: next = IDLE;
            CLR: next = ptr == 5'd31 ? IDLE : CLR;
            DUMP_RD: next = DUMP_OUT;
            DUMP_OUT: if (out_ready) next = ptr == hi ? IDLE : DUMP_RD;
            default: next = IDLE;
        endcase
    end
    // GPR-side outputs are gated by Reset so an aborted command writes nothing at the reset edge
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
    assign RegWrite = !Reset && (state == WR || state == CLR);
    assign RD = RegWrite ? ptr : 5'd0;
    assign WData = (!Reset && state == WR) ? wdata : 32'd0;
    assign RS1 = (!Reset && state == DUMP_RD) ? ptr : 5'd0;
    assign RS2 = 5'd0;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= 5'd0;
            hi <= 5'd0;
            wdata <= 32'd0;
            out_valid <= 1'b0;
            out_idx <= 5'd0;
            out_data <= 32'd0;
            err <= 1'b0;
        end else begin
            state <= next;
            err <= reject;
            if (accept) begin
                ptr <= cmd_op == 2'b10 ? 5'd1 : cmd_lo;
                hi <= cmd_hi;
                wdata <= cmd_wdata;
            end
            if (state == CLR && ptr != 5'd31) ptr <= ptr + 5'd1;
            if (state == DUMP_RD) begin
                out_data <= RData1;
                out_idx <= ptr;
                out_valid <= 1'b1;
            end
            if (state == DUMP_OUT && out_ready) begin
                out_valid <= 1'b0;
                if (ptr != hi) ptr <= ptr + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_gpr_debug_port.sv
// tb_gpr_debug_port: directed bench for gpr_debug_port with a behavioural GPR file
// (combinational read, $0 hardwired to zero) attached to its GPR ports.
module tb_gpr_debug_port;
    logic Clk = 1'b0, Reset = 1'b1, cmd_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_lo = 5'd0, cmd_hi = 5'd0;
    logic [31:0] cmd_wdata = 32'd0, RData2 = 32'd0;
    logic cmd_ready, RegWrite, out_valid, busy, err;
    logic [4:0] RS1, RS2, RD, out_idx;
    logic [31:0] WData, RData1, out_data;
    logic [31:0] gpr [32] = '{default: 32'd0};
    logic [31:0] bd [32];
    int checks = 0, errors = 0, nb, to;

    gpr_debug_port dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_wdata(cmd_wdata),
        .RS1(RS1), .RS2(RS2), .RD(RD), .RegWrite(RegWrite), .WData(WData),
        .RData1(RData1), .RData2(RData2), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .busy(busy), .err(err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) if (RegWrite && RD != 5'd0) gpr[RD] <= WData;
    assign RData1 = gpr[RS1];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] lo, input logic [4:0] hi, input logic [31:0] wd);
        cmd_op = op;
        cmd_lo = lo;
        cmd_hi = hi;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        send(2'b01, idx, 5'd0, data);
        tick();
    endtask

    task automatic run_dump(input logic [4:0] lo, input logic [4:0] hi);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) bd[i] = 32'hBAD0BAD0;
        send(2'b00, lo, hi, 32'd0);
        nb = 0;
        to = 1;
        for (int c = 0; c < 80; c++) begin
            if (!busy) begin
                to = 0;
                break;
            end
            if (out_valid) begin
                bd[out_idx] = out_data;
                nb++;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b exp 1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if ({RegWrite, RD, WData, RS1, RS2} !== 48'd0) begin errors++; $display("FAIL rst_gpr_ports: got %h exp 0", {RegWrite, RD, WData, RS1, RS2}); end
        checks++; if ({out_valid, err, out_idx, out_data} !== 39'd0) begin errors++; $display("FAIL rst_outputs: got %h exp 0", {out_valid, err, out_idx, out_data}); end
    endtask

    task automatic test_write_dump;
        send(2'b01, 5'd6, 5'd0, 32'h2B6);
        checks++; if ({RegWrite, RD, WData} !== {1'b1, 5'd6, 32'h2B6}) begin errors++; $display("FAIL wr_ports: got %b %0d %h exp 1 6 2b6", RegWrite, RD, WData); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_c1: got %b exp 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_c2: got %b exp 0", busy); end
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got %b exp 0", RegWrite); end
        run_dump(5'd6, 5'd6);
        checks++; if (to !== 0) begin errors++; $display("FAIL dump6_timeout: got %0d exp 0", to); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL dump6_beats: got %0d exp 1", nb); end
        checks++; if (bd[6] !== 32'h2B6) begin errors++; $display("FAIL dump6_data: got %h exp 2b6", bd[6]); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dump6_valid_end: got %b exp 0", out_valid); end
    endtask

    task automatic test_multi_dump;
        logic [31:0] exp_d [3] = '{32'h12, 32'h34, 32'h56};
        int bc [3];
        logic [4:0] bi [3];
        logic [31:0] bdat [3];
        int c;
        write_reg(5'd2, 32'h12);
        write_reg(5'd3, 32'h34);
        write_reg(5'd4, 32'h56);
        out_ready = 1'b1;
        send(2'b00, 5'd2, 5'd4, 32'd0);
        checks++; if (RS1 !== 5'd2) begin errors++; $display("FAIL md_rs1: got %0d exp 2", RS1); end
        nb = 0;
        for (c = 1; c <= 20; c++) begin
            if (!busy) break;
            if (out_valid && nb < 3) begin
                bc[nb] = c;
                bi[nb] = out_idx;
                bdat[nb] = out_data;
            end
            if (out_valid) nb++;
            tick();
        end
        checks++; if (nb !== 3) begin errors++; $display("FAIL md_beats: got %0d exp 3", nb); end
        checks++; if (c !== 7) begin errors++; $display("FAIL md_idle_cycle: got %0d exp 7", c); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bc[i], bi[i], bdat[i]} !== {2 * i + 2, 5'(i + 2), exp_d[i]}) begin
                errors++; $display("FAIL md_beat%0d: got c%0d idx %0d %h exp c%0d idx %0d %h", i, bc[i], bi[i], bdat[i], 2 * i + 2, i + 2, exp_d[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] bi [3];
        logic [31:0] bdat [3];
        int held = 0;
        out_ready = 1'b0;
        send(2'b00, 5'd2, 5'd4, 32'd0);
        nb = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            out_ready = !(nb == 1 && out_valid && held < 5);
            if (out_valid && !out_ready) begin
                held++;
                checks++; if ({out_idx, out_data} !== {5'd3, 32'h34}) begin errors++; $display("FAIL bp_hold: got %0d %h exp 3 34", out_idx, out_data); end
            end
            if (out_valid && out_ready) begin
                if (nb < 3) begin
                    bi[nb] = out_idx;
                    bdat[nb] = out_data;
                end
                nb++;
            end
            tick();
        end
        out_ready = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_timeout: got busy %b exp 0", busy); end
        checks++; if (held !== 5) begin errors++; $display("FAIL bp_held: got %0d exp 5", held); end
        checks++; if (nb !== 3) begin errors++; $display("FAIL bp_beats: got %0d exp 3", nb); end
        checks++; if ({bi[0], bi[1], bi[2]} !== {5'd2, 5'd3, 5'd4}) begin errors++; $display("FAIL bp_order: got %0d %0d %0d exp 2 3 4", bi[0], bi[1], bi[2]); end
        checks++; if ({bdat[0], bdat[1], bdat[2]} !== {32'h12, 32'h34, 32'h56}) begin errors++; $display("FAIL bp_data: got %h %h %h exp 12 34 56", bdat[0], bdat[1], bdat[2]); end
    endtask

    task automatic test_clear;
        int n = 0, cyc = 0;
        write_reg(5'd1, 32'hFFFFFFFF);
        write_reg(5'd31, 32'hFFFFFFFF);
        send(2'b10, 5'd0, 5'd0, 32'd0);
        for (int c = 0; c < 40 && busy; c++) begin
            cyc++;
            if (RegWrite) begin
                checks++; if ({RD, WData} !== {5'(n + 1), 32'd0}) begin errors++; $display("FAIL clr_write%0d: got RD %0d WData %h exp %0d 0", n, RD, WData, n + 1); end
                n++;
            end
            tick();
        end
        checks++; if (n !== 31) begin errors++; $display("FAIL clr_count: got %0d exp 31", n); end
        checks++; if (cyc !== 31) begin errors++; $display("FAIL clr_cycles: got %0d exp 31", cyc); end
        run_dump(5'd0, 5'd31);
        checks++; if (to !== 0) begin errors++; $display("FAIL clr_dump_timeout: got %0d exp 0", to); end
        checks++; if (nb !== 32) begin errors++; $display("FAIL clr_dump_beats: got %0d exp 32", nb); end
        for (int i = 0; i < 32; i++) begin
            checks++; if (bd[i] !== 32'd0) begin errors++; $display("FAIL clr_reg%0d: got %h exp 0", i, bd[i]); end
        end
    endtask

    task automatic test_errors;
        send(2'b00, 5'd5, 5'd3, 32'd0);
        checks++; if ({err, cmd_ready, busy, out_valid} !== 4'b1100) begin errors++; $display("FAIL rej_range: got err/rdy/busy/val %b exp 1100", {err, cmd_ready, busy, out_valid}); end
        tick();
        checks++; if ({err, out_valid} !== 2'b00) begin errors++; $display("FAIL rej_range_pulse: got err/val %b exp 00", {err, out_valid}); end
        send(2'b11, 5'd7, 5'd9, 32'hABCD);
        checks++; if ({err, RegWrite, busy} !== 3'b100) begin errors++; $display("FAIL rej_op11: got err/we/busy %b exp 100", {err, RegWrite, busy}); end
        tick();
        checks++; if ({err, RegWrite} !== 2'b00) begin errors++; $display("FAIL rej_op11_pulse: got err/we %b exp 00", {err, RegWrite}); end
        checks++; if (gpr[7] !== 32'd0) begin errors++; $display("FAIL rej_op11_nowrite: got %h exp 0", gpr[7]); end
    endtask

    task automatic test_reset_mid;
        write_reg(5'd1, 32'h11);
        write_reg(5'd9, 32'h99);
        write_reg(5'd10, 32'hA0);
        write_reg(5'd20, 32'h20);
        write_reg(5'd31, 32'h31);
        send(2'b10, 5'd0, 5'd0, 32'd0);
        repeat (9) tick();
        checks++; if ({RegWrite, RD} !== {1'b1, 5'd10}) begin errors++; $display("FAIL rm_pre: got %b %0d exp 1 10", RegWrite, RD); end
        Reset = 1'b1;
        #1;
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rm_we_gated: got %b exp 0", RegWrite); end
        tick();
        Reset = 1'b0;
        #1;
        checks++; if ({cmd_ready, busy, RegWrite} !== 3'b100) begin errors++; $display("FAIL rm_after: got rdy/busy/we %b exp 100", {cmd_ready, busy, RegWrite}); end
        run_dump(5'd1, 5'd31);
        checks++; if (nb !== 31) begin errors++; $display("FAIL rm_beats: got %0d exp 31", nb); end
        checks++; if ({bd[1], bd[9]} !== 64'd0) begin errors++; $display("FAIL rm_cleared: got %h %h exp 0 0", bd[1], bd[9]); end
        checks++; if ({bd[10], bd[20], bd[31]} !== {32'hA0, 32'h20, 32'h31}) begin errors++; $display("FAIL rm_kept: got %h %h %h exp a0 20 31", bd[10], bd[20], bd[31]); end
        out_ready = 1'b0;
        send(2'b00, 5'd10, 5'd10, 32'd0);
        tick();
        checks++; if ({out_valid, out_idx, out_data} !== {1'b1, 5'd10, 32'hA0}) begin errors++; $display("FAIL rm_beat: got %b %0d %h exp 1 10 a0", out_valid, out_idx, out_data); end
        out_ready = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checks++; if ({out_valid, out_idx, out_data, busy} !== 39'd0) begin errors++; $display("FAIL rm_valid_drop: got %b %0d %h %b exp 0", out_valid, out_idx, out_data, busy); end
    endtask

    initial begin
        test_reset();
        test_write_dump();
        test_multi_dump();
        test_backpressure();
        test_clear();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpr_debug_port.md
# gpr_debug_port

Debug initiator for the 32×32 general-purpose register file. It accepts register-transfer commands over a valid/ready handshake and drives the GPR's RS1/RD/RegWrite/WData ports to run them. The supported commands are single-register write, clear-all, and ranged dump. Dumped values leave as a valid/ready stream of (index, data) beats. It sits beside the CPU datapath; an external mux gives it the GPR ports while `busy` is high.

## Interface
- No parameters (register count fixed at 32, data width 32).
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  2  00 = dump range, 01 = write single, 10 = clear all, 11 = reserved
- cmd_lo  in  5  first register (dump) / target register (write)
- cmd_hi  in  5  last register (dump); ignored otherwise
- cmd_wdata  in  32  write data (op 01)
- RS1  out  5  GPR read address 1
- RS2  out  5  GPR read address 2; always 0
- RD  out  5  GPR write address
- RegWrite  out  1  GPR write enable
- WData  out  32  GPR write data
- RData1  in  32  GPR read data 1 (combinational read)
- RData2  in  32  unused
- out_valid  out  1  dump beat valid
- out_ready  in  1  dump beat consumed
- out_idx  out  5  register index of the beat
- out_data  out  32  register value of the beat
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on a rejected command

## Operation
- **States:** IDLE, WR, CLR, DUMP_RD, DUMP_OUT.
- **Accept:** a command is accepted at a rising edge with cmd_valid & cmd_ready. The fields are latched into internal registers.
- **Op 01 (write single):** IDLE → WR.
  - WR lasts one cycle: RD = lo, WData = wdata, RegWrite = 1.
  - Then → IDLE.
  - lo = 0 is still driven; the GPR discards writes to $0.
- **Op 10 (clear all):** IDLE → CLR with ptr = 1.
  - Each CLR cycle: RD = ptr, WData = 0, RegWrite = 1.
  - ptr == 31 → IDLE; otherwise ptr+1.
  - Takes exactly 31 cycles.
- **Op 00 (dump range):**
  - If lo > hi: reject, pulse err, stay in IDLE.
  - Otherwise → DUMP_RD with ptr = lo.
  - DUMP_RD: RS1 = ptr. At the edge, out_data ← RData1, out_idx ← ptr, out_valid ← 1, → DUMP_OUT.
  - DUMP_OUT: hold out_valid, out_idx and out_data stable until out_ready.
  - On the out_valid & out_ready edge: out_valid ← 0. If ptr == hi → IDLE; otherwise ptr+1 → DUMP_RD.
  - ptr never wraps; hi = 31 terminates normally.
- **Op 11:** err pulse, no state change, no GPR activity.
- **Idle port values:** outside WR/CLR, RegWrite = 0, RD = 0 and WData = 0. Outside DUMP_RD, RS1 = 0.
- **Command handshake:** cmd_ready = (state == IDLE), combinational from state. Commands offered while busy are neither accepted nor lost; the source holds them.

## Timing
- **Reset (synchronous, active-high):**
  - state ← IDLE; ptr, out_idx and out_data ← 0; out_valid and err ← 0.
  - All GPR-side outputs are 0.
  - cmd_ready is 1 in the first cycle after Reset deasserts.
- **Reset mid-operation:**
  - Aborts the command at that edge; no further RegWrite from it.
  - A pending out_valid drops at that edge, even if out_ready is high in the same cycle.
  - A CLR interrupted at ptr = k leaves registers 1..k-1 cleared.
- **Latency (accept edge = cycle 0):**
  - Write: RegWrite high in cycle 1; the GPR updates at the end of cycle 1; busy falls at the end of cycle 1.
  - Dump: first out_valid at the end of cycle 1 (visible in cycle 2).
  - Dump throughput: with out_ready held high, one beat per 2 cycles.
  - N-register dump: 2N cycles from accept to IDLE.
  - Clear: 31 cycles of RegWrite, cycles 1–31.
- **Data coherence:**
  - RData1 is sampled in the same cycle RS1 is driven, and the GPR read is combinational.
  - A write completed before the dump is accepted is always visible in the dump.
- **Error output:**
  - err is registered: high for the one cycle after the rejecting edge.
  - cmd_ready stays high through a reject.

## Test plan
- Reset, then write op lo = 6, wdata = 0x2B6, then dump lo = hi = 6 → exactly one beat {idx 6, data 0x2B6}. busy is low 1 cycle after the write accept.
- Write 0x12 to reg 2, 0x34 to reg 3, 0x56 to reg 4, then dump lo = 2, hi = 4 with out_ready = 1:
  - beats (2, 0x12), (3, 0x34), (4, 0x56), 2 cycles apart;
  - returns to IDLE after 6 cycles.
- Same dump with out_ready low for 5 cycles on the second beat → out_valid, idx 3 and data 0x34 held stable; no skipped or duplicated beat.
- Write 0xFFFFFFFF to regs 1 and 31, then clear, then dump 0..31:
  - exactly 31 RegWrite cycles with RD = 1..31;
  - all 32 beats read 0.
- Dump lo = 5, hi = 3 → err pulse 1 cycle, no out_valid. Op 11 → err pulse, RegWrite stays 0.
- Reset asserted in cycle 10 of a clear → RegWrite = 0 from that edge; regs 1–9 read 0 and reg 10 onward keep their old values. cmd_ready = 1 once Reset drops.
